// File: rtl/fault_recovery_controller.sv
// Fault recovery controller: gates architectural writes on unmasked faults,
// flushes with NOPs, replays from a checkpointed PC and escalates to a halted state.
module fault_recovery_controller #(
  parameter int              XLEN         = 32,
  parameter int              NUM_FAULTS   = 4,
  parameter int              NOP_CYCLES   = 2,
  parameter int              MAX_RETRIES  = 3,
  parameter int              CLEAN_WINDOW = 8,
  parameter logic [XLEN-1:0] RESET_PC     = '0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_FAULTS-1:0]           fault_in,
  input  logic [NUM_FAULTS-1:0]           fault_mask,
  input  logic                            clear_fault,
  input  logic                            commit_valid,
  input  logic                            pc_write_normal,
  input  logic                            reg_write_normal,
  input  logic                            mem_write_normal,
  input  logic [XLEN-1:0]                 pc_current,
  input  logic [XLEN-1:0]                 pc_next_normal,
  output logic                            pc_write_out,
  output logic                            reg_write_out,
  output logic                            mem_write_out,
  output logic [XLEN-1:0]                 pc_next,
  output logic                            insert_nop,
  output logic                            retry_en,
  output logic                            halted,
  output logic [$clog2(NUM_FAULTS)-1:0]   fault_cause,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
  output logic [NUM_FAULTS-1:0]           fault_sticky
);

  localparam int CW  = $clog2(NUM_FAULTS);
  localparam int RCW = $clog2(MAX_RETRIES + 1);
  localparam int CLW = $clog2(CLEAN_WINDOW + 1);
  localparam int FW  = $clog2(NOP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_FLUSH,
    ST_RETRY,
    ST_SAFE
  } state_t;

  state_t                 state_reg, state_next;
  logic [XLEN-1:0]        ckpt_reg;
  logic [RCW-1:0]         retry_cnt_reg;
  logic [CLW-1:0]         clean_cnt_reg;
  logic [FW-1:0]          flush_cnt_reg;
  logic [CW-1:0]          cause_reg;
  logic [NUM_FAULTS-1:0]  sticky_reg;

  logic [NUM_FAULTS-1:0]  active;
  logic                   hit;
  logic [CW-1:0]          cause_sel;
  logic                   flush_last;
  logic                   budget_spent;

  assign active       = fault_in & ~fault_mask;
  assign hit          = |active;
  assign flush_last   = (flush_cnt_reg == FW'(NOP_CYCLES - 1));
  assign budget_spent = (retry_cnt_reg == RCW'(MAX_RETRIES));

  // Scan downward so the lowest-numbered active source wins.
  always_comb begin
    cause_sel = '0;
    for (int i = NUM_FAULTS - 1; i >= 0; i--) begin
      if (active[i]) cause_sel = CW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_NORMAL;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (hit) state_next = budget_spent ? ST_SAFE : ST_FLUSH;
      ST_FLUSH:  if (flush_last) state_next = ST_RETRY;
      ST_RETRY:  state_next = ST_NORMAL;
      ST_SAFE:   if (clear_fault) state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ckpt_reg      <= RESET_PC;
      retry_cnt_reg <= '0;
      clean_cnt_reg <= '0;
      flush_cnt_reg <= '0;
      cause_reg     <= '0;
      sticky_reg    <= '0;
    end else begin
      // Set wins over clear so a fault coinciding with clear_fault is not lost.
      sticky_reg <= (clear_fault ? '0 : sticky_reg) | active;

      if (state_reg == ST_FLUSH && !flush_last) flush_cnt_reg <= flush_cnt_reg + FW'(1);
      else                                     flush_cnt_reg <= '0;

      case (state_reg)
        ST_NORMAL: begin
          if (hit) begin
            cause_reg     <= cause_sel;
            clean_cnt_reg <= '0;
            if (!budget_spent) retry_cnt_reg <= retry_cnt_reg + RCW'(1);
          end else if (commit_valid) begin
            ckpt_reg <= pc_current;
            if (clean_cnt_reg == CLW'(CLEAN_WINDOW - 1)) begin
              clean_cnt_reg <= '0;
              retry_cnt_reg <= '0;
            end else begin
              clean_cnt_reg <= clean_cnt_reg + CLW'(1);
            end
          end
        end
        ST_SAFE: begin
          if (clear_fault) begin
            retry_cnt_reg <= '0;
            clean_cnt_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the NORMAL write gating depends on fault_in; the rest decodes the state.
  always_comb begin
    pc_write_out  = 1'b0;
    reg_write_out = 1'b0;
    mem_write_out = 1'b0;
    pc_next       = pc_next_normal;
    insert_nop    = 1'b0;
    retry_en      = 1'b0;
    halted        = 1'b0;
    case (state_reg)
      ST_NORMAL: begin
        pc_write_out  = pc_write_normal & ~hit;
        reg_write_out = reg_write_normal & ~hit;
        mem_write_out = mem_write_normal & ~hit;
      end
      ST_FLUSH: insert_nop = 1'b1;
      ST_RETRY: begin
        retry_en     = 1'b1;
        pc_write_out = 1'b1;
        pc_next      = ckpt_reg;
      end
      ST_SAFE: begin
        halted     = 1'b1;
        insert_nop = 1'b1;
        pc_next    = ckpt_reg;
      end
      default: ;
    endcase
  end

  assign fault_cause  = cause_reg;
  assign retry_count  = retry_cnt_reg;
  assign fault_sticky = sticky_reg;

endmodule

// File: tb/tb_fault_recovery_controller.sv
// Directed bench for fault_recovery_controller: a vector table for the basic
// fault/mask/sticky flow plus hand sequences for escalation, clean window and async reset.
module tb_fault_recovery_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  fault_in, fault_mask;
  logic        clear_fault, commit_valid;
  logic        pc_write_normal, reg_write_normal, mem_write_normal;
  logic [31:0] pc_current, pc_next_normal;
  logic        pc_write_out, reg_write_out, mem_write_out;
  logic [31:0] pc_next;
  logic        insert_nop, retry_en, halted;
  logic [1:0]  fault_cause, retry_count;
  logic [3:0]  fault_sticky;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fault_recovery_controller dut (
    .clk(clk), .reset_n(reset_n), .fault_in(fault_in), .fault_mask(fault_mask),
    .clear_fault(clear_fault), .commit_valid(commit_valid),
    .pc_write_normal(pc_write_normal), .reg_write_normal(reg_write_normal),
    .mem_write_normal(mem_write_normal), .pc_current(pc_current),
    .pc_next_normal(pc_next_normal), .pc_write_out(pc_write_out),
    .reg_write_out(reg_write_out), .mem_write_out(mem_write_out), .pc_next(pc_next),
    .insert_nop(insert_nop), .retry_en(retry_en), .halted(halted),
    .fault_cause(fault_cause), .retry_count(retry_count), .fault_sticky(fault_sticky)
  );

  typedef struct {
    logic [3:0]  f;
    logic [3:0]  m;
    logic        c;
    logic [31:0] pcc;
    logic        clr;
    logic [2:0]  we;
    logic [31:0] pcn;
    logic        nop;
    logic        rty;
    logic        hlt;
    logic [1:0]  cause;
    logic [1:0]  rc;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic [3:0] f, logic [3:0] m, logic c, logic [31:0] pcc,
                              logic clr, logic [2:0] we, logic [31:0] pcn, logic nop,
                              logic rty, logic hlt, logic [1:0] cause, logic [1:0] rc,
                              logic [3:0] st);
    vec_t v;
    v.f = f; v.m = m; v.c = c; v.pcc = pcc; v.clr = clr;
    v.we = we; v.pcn = pcn; v.nop = nop; v.rty = rty; v.hlt = hlt;
    v.cause = cause; v.rc = rc; v.st = st;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are
  // sampled at the falling edge.
  task automatic cyc(logic [3:0] f, logic [3:0] m, logic c, logic [31:0] pcc, logic clr);
    @(posedge clk);
    #1;
    fault_in = f; fault_mask = m; commit_valid = c; pc_current = pcc; clear_fault = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(4'b0000, 4'b0000, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    fault_in = '0; fault_mask = '0; commit_valid = 0; pc_current = '0; clear_fault = 0;
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  function automatic logic [2:0] we_now();
    return {pc_write_out, reg_write_out, mem_write_out};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    pc_write_normal = 1; reg_write_normal = 1; mem_write_normal = 1;
    pc_next_normal  = 32'h14;

    //            f       m      c  pcc     clr we      pcn     nop rty hlt cause rc  st
    tbl[0]  = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b111, 32'h14, 0, 0, 0, 2'd0, 2'd0, 4'b0000);
    tbl[1]  = mk(4'h0, 4'h0, 1, 32'h10, 0, 3'b111, 32'h14, 0, 0, 0, 2'd0, 2'd0, 4'b0000);
    tbl[2]  = mk(4'h4, 4'h0, 0, 32'h0,  0, 3'b000, 32'h14, 0, 0, 0, 2'd0, 2'd0, 4'b0000);
    tbl[3]  = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b000, 32'h14, 1, 0, 0, 2'd2, 2'd1, 4'b0100);
    tbl[4]  = mk(4'h1, 4'h0, 1, 32'h40, 0, 3'b000, 32'h14, 1, 0, 0, 2'd2, 2'd1, 4'b0100);
    tbl[5]  = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b100, 32'h10, 0, 1, 0, 2'd2, 2'd1, 4'b0101);
    tbl[6]  = mk(4'h0, 4'h0, 0, 32'h0,  1, 3'b111, 32'h14, 0, 0, 0, 2'd2, 2'd1, 4'b0101);
    tbl[7]  = mk(4'h1, 4'h1, 0, 32'h0,  0, 3'b111, 32'h14, 0, 0, 0, 2'd2, 2'd1, 4'b0000);
    tbl[8]  = mk(4'h3, 4'h1, 0, 32'h0,  0, 3'b000, 32'h14, 0, 0, 0, 2'd2, 2'd1, 4'b0000);
    tbl[9]  = mk(4'h8, 4'h0, 0, 32'h0,  1, 3'b000, 32'h14, 1, 0, 0, 2'd1, 2'd2, 4'b0010);
    tbl[10] = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b000, 32'h14, 1, 0, 0, 2'd1, 2'd2, 4'b1000);
    tbl[11] = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b100, 32'h10, 0, 1, 0, 2'd1, 2'd2, 4'b1000);
    tbl[12] = mk(4'h0, 4'h0, 0, 32'h0,  0, 3'b111, 32'h14, 0, 0, 0, 2'd1, 2'd2, 4'b1000);

    do_reset();
    chk("reset_state", {we_now(), pc_next, insert_nop, retry_en, halted, fault_cause,
                        retry_count, fault_sticky},
        {3'b111, 32'h14, 3'b000, 2'd0, 2'd0, 4'b0000});

    for (int i = 0; i < 13; i++) begin
      cyc(tbl[i].f, tbl[i].m, tbl[i].c, tbl[i].pcc, tbl[i].clr);
      chk($sformatf("vec%0d", i),
          {we_now(), pc_next, insert_nop, retry_en, halted, fault_cause, retry_count,
           fault_sticky},
          {tbl[i].we, tbl[i].pcn, tbl[i].nop, tbl[i].rty, tbl[i].hlt, tbl[i].cause,
           tbl[i].rc, tbl[i].st});
    end

    // Escalation: three retries, fourth fault goes to SAFE
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(4'h1, 4'h0, 0, 32'h0, 0);
      chk($sformatf("esc_gate%0d", k), we_now(), 3'b000);
      idle(); idle(); idle();
      chk($sformatf("esc_retry%0d", k), {retry_en, retry_count}, {1'b1, 2'(k + 1)});
    end
    idle();
    cyc(4'h1, 4'h0, 0, 32'h0, 0);
    chk("esc_gate3", we_now(), 3'b000);
    for (int k = 0; k < 20; k++) begin
      idle();
      chk($sformatf("safe_hold%0d", k), {halted, insert_nop, retry_en, we_now(), pc_next,
                                         retry_count},
          {3'b110, 3'b000, 32'h0, 2'd3});
    end
    cyc(4'h0, 4'h0, 0, 32'h0, 1);
    chk("safe_clear_cycle", halted, 1'b1);
    idle();
    chk("safe_exit", {halted, insert_nop, we_now(), retry_count, fault_sticky},
        {2'b00, 3'b111, 2'd0, 4'b0000});

    // Clean window: 8 commits after a retry forgive the retry count
    do_reset();
    cyc(4'h2, 4'h0, 0, 32'h0, 0); idle(); idle(); idle(); idle();
    chk("cw_start", retry_count, 2'd1);
    for (int k = 0; k < 8; k++) cyc(4'h0, 4'h0, 1, 32'h100 + 32'(4 * k), 0);
    chk("cw_after7", retry_count, 2'd1);
    idle();
    chk("cw_after8", retry_count, 2'd0);
    cyc(4'h2, 4'h0, 0, 32'h0, 0); idle(); idle(); idle();
    chk("cw_ckpt_replay", {retry_en, pc_next, retry_count}, {1'b1, 32'h11C, 2'd1});

    // Fault on the 7th commit instead
    do_reset();
    cyc(4'h2, 4'h0, 0, 32'h0, 0); idle(); idle(); idle(); idle();
    for (int k = 0; k < 6; k++) cyc(4'h0, 4'h0, 1, 32'h200 + 32'(4 * k), 0);
    cyc(4'h2, 4'h0, 1, 32'h300, 0);
    chk("cw7_gate", we_now(), 3'b000);
    idle(); idle(); idle();
    chk("cw7_retry", {retry_en, pc_next, retry_count}, {1'b1, 32'h214, 2'd2});
    idle();
    chk("cw7_normal", retry_count, 2'd2);

    // Asynchronous reset in the first FLUSH cycle
    do_reset();
    cyc(4'h0, 4'h0, 1, 32'h20, 0);
    cyc(4'h2, 4'h0, 0, 32'h0, 0);
    idle();
    chk("ar_flush", insert_nop, 1'b1);
    #2 reset_n = 0;
    #1;
    chk("ar_immediate", {insert_nop, retry_en, halted, retry_count, fault_sticky},
        {3'b000, 2'd0, 4'b0000});
    @(negedge clk);
    reset_n = 1;
    idle();
    chk("ar_normal", {we_now(), pc_next, insert_nop}, {3'b111, 32'h14, 1'b0});
    cyc(4'h2, 4'h0, 0, 32'h0, 0); idle(); idle(); idle();
    chk("ar_ckpt", {retry_en, pc_next}, {1'b1, 32'h0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fault_recovery_controller.md
# fault_recovery_controller

Parametrised successor to the CPU's fault-tolerant control block. It sits between the decode/control path and the architectural write enables. It monitors `NUM_FAULTS` independently maskable fault sources, suppresses writes on detection and flushes the pipeline with a configurable number of NOP cycles. It then replays from a checkpointed PC and escalates to a halted safe state when the retry budget is exhausted. It also keeps sticky fault status, a latched fault cause and a retry counter that is forgiven after a window of clean commits.

## Interface
- `XLEN`, 32: PC width.
- `NUM_FAULTS`, 4: number of fault sources; min 2.
- `NOP_CYCLES`, 2: flush length in cycles; min 1.
- `MAX_RETRIES`, 3: retries allowed before escalation; min 1.
- `CLEAN_WINDOW`, 8: fault-free commits needed to zero `retry_count`; min 1.
- `RESET_PC`, 32'h0000_0000: checkpoint value after reset.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fault_in`  in  NUM_FAULTS  per-source fault flags, level, sampled every cycle.
- `fault_mask`  in  NUM_FAULTS  1 = ignore that source.
- `clear_fault`  in  1  single-cycle pulse; exits SAFE and clears sticky status.
- `commit_valid`  in  1  instruction at `pc_current` retires this cycle.
- `pc_write_normal`, `reg_write_normal`, `mem_write_normal`  in  1 each  write enables from the normal control path.
- `pc_current`  in  XLEN  PC of the instruction in the execute/commit stage.
- `pc_next_normal`  in  XLEN  next PC from the normal path.
- `pc_write_out`, `reg_write_out`, `mem_write_out`  out  1 each  gated write enables.
- `pc_next`  out  XLEN  selected next PC.
- `insert_nop`  out  1  force NOP into the pipeline.
- `retry_en`  out  1  replay strobe.
- `halted`  out  1  high in SAFE.
- `fault_cause`  out  $clog2(NUM_FAULTS)  index of the lowest-numbered unmasked active fault, latched at detection.
- `retry_count`  out  $clog2(MAX_RETRIES+1)  retries consumed.
- `fault_sticky`  out  NUM_FAULTS  OR of all unmasked faults seen since reset or the last `clear_fault`.

## Operation
- `hit = |(fault_in & ~fault_mask)`.
- FSM states: NORMAL, FLUSH, RETRY, SAFE.
- NORMAL, no `hit`:
  - Write enables pass through; `pc_next = pc_next_normal`; `insert_nop`, `retry_en` and `halted` are 0.
  - On `commit_valid`, the checkpoint register takes `pc_current`.
  - On `commit_valid`, `clean_cnt` increments. When it reaches `CLEAN_WINDOW`, `retry_count` and `clean_cnt` both go to 0.
- NORMAL with `hit`:
  - Same-cycle outputs (combinational): all three write enables are 0 and the checkpoint is not updated.
  - At the edge: `fault_cause` and `fault_sticky` update and `clean_cnt` goes to 0.
  - If `retry_count == MAX_RETRIES`, go to SAFE. Otherwise `retry_count` increments and the FSM goes to FLUSH.
- FLUSH:
  - Lasts exactly `NOP_CYCLES` cycles, counted by an internal counter.
  - `insert_nop` = 1 and all write enables are 0.
  - Then go to RETRY.
- RETRY:
  - Lasts one cycle: `retry_en` = 1, `pc_write_out` = 1, `pc_next` = checkpoint, reg/mem writes 0.
  - Then go to NORMAL.
- SAFE:
  - `halted` = 1, `insert_nop` = 1, all write enables 0, `pc_next` = checkpoint.
  - Stays in SAFE until `clear_fault`. Then go to NORMAL with `retry_count`, `clean_cnt` and `fault_sticky` all 0.
- Faults seen during FLUSH, RETRY or SAFE set `fault_sticky` bits but never restart or extend the sequence. `fault_cause` holds its value.
- `clear_fault` outside SAFE clears `fault_sticky` only. If a fault is present in the same cycle, the fault's sticky bit is set (set wins over clear).
- Sticky update rule: `fault_sticky <= (clear ? 0 : fault_sticky) | (fault_in & ~fault_mask)`.

## Timing
- Reset values:
  - State NORMAL; checkpoint `RESET_PC`.
  - `retry_count`, `clean_cnt`, FLUSH counter, `fault_cause` and `fault_sticky` all 0.
  - `halted`, `insert_nop` and `retry_en` are 0.
  - Write enables and `pc_next` follow the NORMAL pass-through.
- Reset takes effect asynchronously, including in the middle of FLUSH, RETRY or SAFE. Release is synchronous to `clk`.
- Fault detected in cycle T:
  - T: writes suppressed.
  - T+1 to T+NOP_CYCLES: FLUSH.
  - T+NOP_CYCLES+1: RETRY.
  - T+NOP_CYCLES+2: NORMAL.
- The escalation decision uses the value of `retry_count` registered before cycle T.
- In SAFE, the cycle in which `clear_fault` is sampled is still halted. NORMAL starts on the next cycle.
- The `fault_in` to write-enable path is combinational. All other outputs are registered state or decoded directly from the current state.

## Test plan
- Reset, then pass-through. Drive `reset_n` = 0 then 1, all normal enables = 1, `pc_next_normal` = 0x14. Required: all `*_out` = 1, `pc_next` = 0x14, `halted` = 0, `retry_count` = 0.
- Single fault. Commit at `pc_current` = 0x10, then `fault_in` = 4'b0100 for one cycle. Required:
  - Writes are 0 in the same cycle.
  - `insert_nop` = 1 for 2 cycles.
  - Then one cycle of `retry_en` = 1, `pc_write_out` = 1, `pc_next` = 0x10.
  - `fault_cause` = 2, `retry_count` = 1, `fault_sticky` = 4'b0100.
- Escalation. Four faults with fewer than 8 commits between them. Required: the 4th fault leads to SAFE, with `halted` = 1 and writes 0 held for 20 cycles. After a `clear_fault` pulse the next cycle is NORMAL with `retry_count` = 0 and `fault_sticky` = 0.
- Masking and priority. With `fault_mask` = 4'b0001, `fault_in` = 4'b0001 causes no reaction. `fault_in` = 4'b0011 gives `fault_cause` = 1 and `fault_sticky` = 4'b0010.
- Clean window. After one retry, 8 fault-free commits bring `retry_count` back to 0. A fault on the 7th commit instead leaves `retry_count` = 2.
- Asynchronous reset mid-FLUSH. Assert `reset_n` = 0 in the first FLUSH cycle. Required: `insert_nop` drops to 0 immediately, and after release the checkpoint is 0x0 and the state is NORMAL.
